// File: rtl/seg_pkg.sv
// Shared constants, states and helpers for the seven-segment scanner.
// Holds the active-low font, blank/dash glyphs and the BCD width helper.
package seg_pkg;

    // Active-low segment patterns: bit 7 = dp, bits 6..0 = g..a.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_e;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] s;
        case (nibble)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    // Decimal digits needed for a w-bit unsigned value: ceil(w/3).
    function automatic int BCD_DIGITS(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle.
// Ports: clk, rst_n, start, bin[W], busy, done (1-cycle), bcd[4*ND].
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int W  = 32,
    parameter int ND = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd
);

    localparam int CNTW = $clog2(W + 1);

    conv_state_e     state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [4*ND-1:0] bcd_q, bcd_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [4*ND-1:0] adj;
    logic [4*ND-1:0] step;
    logic            last;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        step = (adj << 1)
             | {{(4*ND-1){1'b0}}, bin_q[W-1]};
    end

    assign last = (cnt_q == CNTW'(1));

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    state_d = CONV_RUN;
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = CNTW'(W);
                end
            end
            default: begin
                bin_d = bin_q << 1;
                bcd_d = step;
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    state_d = CONV_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    // The final step result is presented combinationally with done so
    // the consumer can latch the whole value on the last busy cycle.
    assign busy = (state_q == CONV_RUN);
    assign done = busy && last;
    assign bcd  = step;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with hex/decimal load, LZ blanking.
// Ports: in_data/in_valid/mode load, blank_lz/dp/blink live, busy,
// segment_led (active-low), seg_en (active-low one-hot).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp,
    input  logic [DIGITS-1:0] blink,
    output logic              busy,
    output logic [7:0]        segment_led,
    output logic [DIGITS-1:0] seg_en
);

    localparam int ND  = BCD_DIGITS(DATA_W);
    localparam int BW  = 4 * DIGITS;
    localparam int PW  = (DATA_W > BW) ? DATA_W : BW;
    localparam int CW  = (4 * ND > BW) ? 4 * ND : BW;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PSW = $clog2(SCAN_DIV);
    localparam int FW  =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic              load, hex_ld, dec_ld;
    logic              conv_busy, conv_done;
    logic [4*ND-1:0]   conv_bcd;
    logic [PW-1:0]     hex_pad;
    logic [CW-1:0]     bcd_pad;

    logic [BW-1:0]     buf_q, buf_d;
    logic              ovf_q, ovf_d;
    logic [PSW-1:0]    presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              blon_q, blon_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] en_q, en_d;

    logic              tc, wrap;
    logic [3:0]        nib;
    logic [7:0]        glyph;
    logic              hi_zero, lz_blank, bl_blank;

    assign load   = in_valid && !conv_busy;
    assign hex_ld = load && !mode;
    assign dec_ld = load && mode;

    bin2bcd_seq #(
        .W  (DATA_W),
        .ND (ND)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dec_ld),
        .bin   (in_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy    = conv_busy;
    assign hex_pad = PW'(in_data);
    assign bcd_pad = CW'(conv_bcd);

    // Overflow is only decided once the full conversion is known, so the
    // old picture stays intact until the new one replaces it.
    always_comb begin
        buf_d = buf_q;
        ovf_d = ovf_q;
        if (hex_ld) begin
            buf_d = hex_pad[BW-1:0];
            ovf_d = 1'b0;
        end else if (conv_done) begin
            buf_d = bcd_pad[BW-1:0];
            ovf_d = |(bcd_pad >> BW);
        end
    end

    always_comb begin
        tc      = (presc_q == PSW'(SCAN_DIV - 1));
        wrap    = tc && (idx_q == IW'(DIGITS - 1));
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        frame_d = frame_q;
        blon_d  = blon_q;
        if (tc) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blon_d  = ~blon_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and everything above it is zero.
    always_comb begin
        nib      = buf_q[{idx_q, 2'b00} +: 4];
        hi_zero  = ((buf_q >> {idx_q, 2'b00}) == '0);
        lz_blank = blank_lz && !ovf_q && (idx_q != '0) && hi_zero;
        bl_blank = blink[idx_q] && !blon_q;
        glyph    = ovf_q ? SEG_DASH : hex_to_seg(nib);
        seg_d    = SEG_BLANK;
        en_d     = '1;
        if (!(lz_blank || bl_blank)) begin
            seg_d = {~dp[idx_q], glyph[6:0]};
            en_d  = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            blon_q  <= 1'b1;
            seg_q   <= SEG_BLANK;
            en_q    <= '1;
        end else begin
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            blon_q  <= blon_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
        end
    end

    assign segment_led = seg_q;
    assign seg_en      = en_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 16-bit, fast scan).
// Stimulus queues expected digit pictures; a monitor matches them.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DATA_W = 16;
    localparam int SDIV   = 4;
    localparam int BFR    = 2;

    typedef struct {
        int         dig;
        int         ph;
        logic [3:0] en;
        logic [7:0] seg;
        string      name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              mode;
    logic              blank_lz;
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] blink;
    logic              busy;
    logic [7:0]        segment_led;
    logic [DIGITS-1:0] seg_en;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   bhi;
    int   bcnt;
    int   g;
    exp_t sb[$];

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .DATA_W       (DATA_W),
        .SCAN_DIV     (SDIV),
        .BLINK_FRAMES (BFR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .mode        (mode),
        .blank_lz    (blank_lz),
        .dp          (dp),
        .blink       (blink),
        .busy        (busy),
        .segment_led (segment_led),
        .seg_en      (seg_en)
    );

    always #5 clk = ~clk;

    // Edges since reset release; pins after edge n show the scan
    // position of the cycle before edge n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int  d;
        bit  on;
        bit  phok;
        exp_t e;
        if (rst_n && cyc >= 1 && sb.size() > 0) begin
            d    = ((cyc - 1) / SDIV) % DIGITS;
            on   = (((cyc - 1) / (SDIV * DIGITS * BFR)) % 2) == 0;
            phok = (sb[0].ph == 0)
                || (sb[0].ph == 1 && on)
                || (sb[0].ph == 2 && !on);
            if (sb[0].dig == d && phok) begin
                e = sb.pop_front();
                checks++;
                if (seg_en !== e.en || segment_led !== e.seg) begin
                    errors++;
                    $display("FAIL %s dig%0d: got en=%h seg=%h want en=%h seg=%h",
                             e.name, e.dig, seg_en, segment_led,
                             e.en, e.seg);
                end
            end
        end
    end

    task automatic check(input string nm, input int got,
                         input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic expect_dig(input string nm, input int dig,
                              input int ph, input logic [3:0] en,
                              input logic [7:0] seg);
        exp_t e;
        e.dig  = dig;
        e.ph   = ph;
        e.en   = en;
        e.seg  = seg;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) bhi++;
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() > 0 && k < 300) begin
            @(negedge clk);
            if (busy) bhi++;
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d pending", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic load(input logic [15:0] d, input logic m);
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) check({nm, "_idle"}, 1, 0);
    endtask

    initial begin
        in_data  = '0;
        in_valid = 1'b0;
        mode     = 1'b0;
        blank_lz = 1'b0;
        dp       = '0;
        blink    = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg", segment_led, 8'hFF);
        check("rst_en", seg_en, 4'hF);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // 1: hex load
        bhi = 0;
        load(16'h1A3F, 1'b0);
        tick(2);
        expect_dig("hex", 0, 0, 4'hE, 8'h8E);
        expect_dig("hex", 1, 0, 4'hD, 8'hB0);
        expect_dig("hex", 2, 0, 4'hB, 8'h88);
        expect_dig("hex", 3, 0, 4'h7, 8'hF9);
        drain("hex");
        check("hex_busy", bhi, 0);

        // 2: decimal load, second strobe dropped
        load(16'd1234, 1'b1);
        bcnt = 0;
        g    = 0;
        while (busy && g < 100) begin
            bcnt++;
            g++;
            in_valid = (bcnt == 3);
            in_data  = 16'hFFFF;
            mode     = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("dec_busy_len", bcnt, 16);
        tick(2);
        expect_dig("dec", 0, 0, 4'hE, 8'h99);
        expect_dig("dec", 1, 0, 4'hD, 8'hB0);
        expect_dig("dec", 2, 0, 4'hB, 8'hA4);
        expect_dig("dec", 3, 0, 4'h7, 8'hF9);
        drain("dec");

        // 3: overflow then cleared
        load(16'd56789, 1'b1);
        wait_idle("ovf");
        tick(2);
        expect_dig("ovf", 0, 0, 4'hE, 8'hBF);
        expect_dig("ovf", 1, 0, 4'hD, 8'hBF);
        expect_dig("ovf", 2, 0, 4'hB, 8'hBF);
        expect_dig("ovf", 3, 0, 4'h7, 8'hBF);
        drain("ovf");
        load(16'h0007, 1'b0);
        tick(2);
        expect_dig("ovf_clr", 0, 0, 4'hE, 8'hF8);
        expect_dig("ovf_clr", 3, 0, 4'h7, 8'hC0);
        drain("ovf_clr");

        // 4: leading-zero blanking
        blank_lz = 1'b1;
        load(16'h0005, 1'b0);
        tick(2);
        expect_dig("lz5", 0, 0, 4'hE, 8'h92);
        expect_dig("lz5", 1, 0, 4'hF, 8'hFF);
        expect_dig("lz5", 2, 0, 4'hF, 8'hFF);
        expect_dig("lz5", 3, 0, 4'hF, 8'hFF);
        drain("lz5");
        load(16'h0000, 1'b0);
        tick(2);
        expect_dig("lz0", 0, 0, 4'hE, 8'hC0);
        expect_dig("lz0", 1, 0, 4'hF, 8'hFF);
        expect_dig("lz0", 3, 0, 4'hF, 8'hFF);
        drain("lz0");
        blank_lz = 1'b0;

        // 5: blink and decimal point
        load(16'h4321, 1'b0);
        blink = 4'b0001;
        dp    = 4'b0100;
        tick(2);
        expect_dig("blk_on", 0, 1, 4'hE, 8'hF9);
        expect_dig("dp2", 2, 0, 4'hB, 8'h30);
        expect_dig("blk_off", 0, 2, 4'hF, 8'hFF);
        expect_dig("dig1", 1, 0, 4'hD, 8'hA4);
        expect_dig("blk_on2", 0, 1, 4'hE, 8'hF9);
        drain("blink");
        blink = '0;
        dp    = '0;

        // 6: reset in the middle of a conversion
        load(16'd999, 1'b1);
        repeat (7) @(negedge clk);
        check("mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_seg", segment_led, 8'hFF);
        check("arst_en", seg_en, 4'hF);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_dig("post_rst", 0, 0, 4'hE, 8'hC0);
        expect_dig("post_rst", 3, 0, 4'h7, 8'hC0);
        drain("post_rst");
        check("post_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment display controller, the successor to the fixed 8-digit hex `segment` scanner driven from the CPU top level. It adds:
- a configurable digit count and scan rate;
- an unsigned decimal mode using a sequential binary-to-BCD converter;
- leading-zero blanking, an overflow indication, and per-digit decimal-point and blink control.

It sits between the CPU's display register (e.g. the LED/`$t8` mirror) and the board's `segment_led`/`seg_en` pins.

## Interface
- `DIGITS`, 8, number of digits scanned; legal 1..8.
- `DATA_W`, 32, width of `in_data`; legal 4..32.
- `SCAN_DIV`, 100000, clock cycles each digit is lit; ≥2.
- `BLINK_FRAMES`, 64, full scan frames per blink half-period; ≥1.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  DATA_W  value to display.
- `in_valid`  in  1  load strobe, one cycle; ignored while `busy`=1.
- `mode`  in  1  0 = hex, 1 = unsigned decimal; captured with `in_valid`.
- `blank_lz`  in  1  1 = blank leading zeros; sampled live.
- `dp`  in  DIGITS  decimal point per digit, 1 = lit; sampled live.
- `blink`  in  DIGITS  1 = digit blinks; sampled live.
- `busy`  out  1  decimal conversion in progress.
- `segment_led`  out  8  active-low segments; bit 7 = dp, bits 6..0 = g..a.
- `seg_en`  out  DIGITS  active-low one-hot digit enable; digit 0 is the rightmost.

## Operation
**Load**
- `in_valid` with `busy`=0 captures `in_data` and `mode`.
- Hex mode writes the display buffer directly: digit i = `in_data[4i+3:4i]`. Bits above 4·DIGITS are ignored, and any missing upper bits read as 0.
- Decimal mode starts `bin2bcd_seq`, which performs one shift-add-3 per cycle for DATA_W cycles. The result is written to the buffer atomically, so no partial values are ever shown.
- Overflow: if any BCD digit at index ≥ DIGITS is nonzero, the buffer is flagged overflow and every digit shows a dash (0xBF, dp still applied). Any later load clears the flag.

**Scan**
- A prescaler counts 0..SCAN_DIV-1. At terminal count, the digit index advances 0→DIGITS-1 and wraps to 0.
- The frame counter increments on each index wrap. The blink phase toggles every BLINK_FRAMES frames, and its reset phase is "on".

**Digit rendering**
- Blank (segments 0xFF, `seg_en` bit stays 1) when either:
  - the digit is blinking and the blink phase is "off"; or
  - `blank_lz`=1, the digit lies above the most significant nonzero digit, and the digit is not digit 0.
- Leading-zero blanking does not apply in overflow.
- Otherwise `segment_led` = font(nibble) with bit 7 = ~dp[i].

**Font (active-low, dp off)**
- 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
- 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E

**Boundary behaviour**
- `in_valid` while `busy`=1 is dropped, with no queueing.
- A load completing in the same cycle that the index wraps is harmless: outputs follow the buffer on the next cycle.
- Asserting `rst_n` mid-conversion aborts it, and the buffer returns to zero.

## Timing
**Reset values**
- `segment_led`=0xFF, `seg_en`=all 1s, `busy`=0.
- Buffer = 0, index = 0, prescaler = 0, overflow = 0.

**Output timing**
- `segment_led` and `seg_en` are registered: they reflect the index, buffer, `dp`, `blink` and `blank_lz` values of the previous cycle.
- After reset release, digit 0 is driven from the first clock edge.

**Latency**
- Hex load: `in_valid` at cycle t, buffer updated at t+1, pins at t+2. `busy` stays 0.
- Decimal load: `in_valid` at cycle t, `busy`=1 for cycles t+1..t+DATA_W, buffer updated at t+DATA_W+1 when `busy` falls, pins at t+DATA_W+2.
- A new `in_valid` is accepted in the first cycle `busy`=0.
- The digit changes every SCAN_DIV cycles. One frame is DIGITS·SCAN_DIV cycles.

## Structure
- Package `seg_pkg` holds:
  - the font constants, `SEG_BLANK`=8'hFF and `SEG_DASH`=8'hBF;
  - function `hex_to_seg(nibble)`;
  - `BCD_DIGITS(w)` = ceil(w/3), the converter's digit count.
- Sub-module `bin2bcd_seq` is the sequential double-dabble converter. Ports: `start`, `bin`, `busy`, `done` (1-cycle pulse), `bcd`.
- The top level contains the load logic, buffer, prescaler, index, frame and blink counters, and the output registers.

## Test plan
Bench parameters: DIGITS=4, DATA_W=16, SCAN_DIV=4, BLINK_FRAMES=2.
1. Reset, then hex load 0x1A3F → over one frame, `seg_en` cycles E,D,B,7 with `segment_led` 8E,B0,88,F9 respectively. `busy` never rises.
2. Decimal load 16'd1234 → `busy` high for exactly 16 cycles, then digits 0..3 = 99,B0,A4,F9. A second `in_valid` during `busy` produces no change.
3. Decimal load 16'd56789 → all four digits show BF (overflow). A subsequent hex load 0x0007 clears it.
4. Hex load 0x0005 with `blank_lz`=1 → digits 1..3 blank (FF, enable high), digit 0 = 92. Load 0x0000 → digit 0 = C0, digits 1..3 blank.
5. `blink`=4'b0001, `dp`=4'b0100 → digit 0 is alternately lit and blank every 2 frames, and digit 2 has bit 7 = 0.
6. Pull `rst_n` low at the 8th busy cycle of a decimal load → outputs FF/F immediately (asynchronous), `busy`=0. After release, digit 0 shows C0.
